axis_pkt_arbiter: RTL and testbench

Packet-granular round-robin arbiter that shares one 512-bit AXI4-Stream datapath between N requesting streams. It sits in front of the network kernel's shared TX path and feeds a single downstream consumer. Once a requester wins, it holds the datapath until its `tlast` beat is accepted. The output is fully registered through a 2-entry skid buffer, so there is no combinational path from `m_axis_tready` to any `s_axis_tready`.

---
 rtl/axis_arb_pkg.sv | 25 ++
 rtl/rr_select.sv | 28 ++
 rtl/axis_pkt_arbiter.sv | 150 +++++++++++++++
 tb/tb_axis_pkt_arbiter.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_arb_pkg.sv
// Shared types and helpers for the packet-granular AXI4-Stream arbiter.
package axis_arb_pkg;

  localparam int DATA_W_DEFAULT = 512;
  localparam int KEEP_W_DEFAULT = 64;

  typedef struct packed {
    logic [DATA_W_DEFAULT-1:0] data;
    logic [KEEP_W_DEFAULT-1:0] keep;
    logic                      last;
  } axis_beat_t;

  typedef enum logic {IDLE, LOCKED} arb_state_t;

  // Index of the set bit in a one-hot vector (up to 16 requesters).
  function automatic int onehot_to_idx(input logic [15:0] oh);
    int idx;
    idx = 0;
    for (int i = 0; i < 16; i++) begin
      if (oh[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_select.sv
// Combinational round-robin pick: first requester at or after rr_ptr_i, wrapping.
module rr_select #(
  parameter int N_PORTS = 4,
  parameter int PTR_W   = $clog2(N_PORTS)
) (
  input  logic [N_PORTS-1:0] req_i,
  input  logic [PTR_W-1:0]   rr_ptr_i,
  output logic [N_PORTS-1:0] winner_o,
  output logic               any_req_o
);

  always_comb begin
    int   idx;
    logic found;
    winner_o = '0;
    found    = 1'b0;
    idx      = 0;
    for (int k = 0; k < N_PORTS; k++) begin
      idx = (int'(rr_ptr_i) + k) % N_PORTS;
      if (!found && req_i[idx]) begin
        winner_o[idx] = 1'b1;
        found         = 1'b1;
      end
    end
    any_req_o = found;
  end

endmodule

// File: rtl/axis_pkt_arbiter.sv
// Packet-granular round-robin arbiter sharing one AXI4-Stream datapath among N_PORTS
// requesters; output is fully registered through a 2-entry skid buffer.
module axis_pkt_arbiter
  import axis_arb_pkg::*;
#(
  parameter int N_PORTS = 4,
  parameter int DATA_W  = DATA_W_DEFAULT
) (
  input  logic                           aclk,
  input  logic                           areset,
  input  logic [N_PORTS-1:0]             s_axis_tvalid,
  output logic [N_PORTS-1:0]             s_axis_tready,
  input  logic [N_PORTS*DATA_W-1:0]      s_axis_tdata,
  input  logic [N_PORTS*(DATA_W/8)-1:0]  s_axis_tkeep,
  input  logic [N_PORTS-1:0]             s_axis_tlast,
  output logic                           m_axis_tvalid,
  input  logic                           m_axis_tready,
  output logic [DATA_W-1:0]              m_axis_tdata,
  output logic [DATA_W/8-1:0]            m_axis_tkeep,
  output logic                           m_axis_tlast,
  output logic [N_PORTS-1:0]             grant,
  output logic                           busy
);

  localparam int KEEP_W = DATA_W / 8;
  localparam int PTR_W  = $clog2(N_PORTS);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [KEEP_W-1:0] keep;
    logic              last;
  } beat_t;

  arb_state_t         state_q, state_d;
  logic [N_PORTS-1:0] grant_q, grant_d;
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  beat_t              head_q, head_d, tail_q, tail_d;
  logic [1:0]         count_q, count_d;
  logic               full_q;
  beat_t              in_beat;
  logic [N_PORTS-1:0] winner;
  logic               any_req;
  logic               push, pop;
  int                 grant_idx;

  rr_select #(.N_PORTS(N_PORTS), .PTR_W(PTR_W)) u_rr_select (
    .req_i    (s_axis_tvalid),
    .rr_ptr_i (rr_ptr_q),
    .winner_o (winner),
    .any_req_o(any_req)
  );

  // Ready depends only on registered state, so m_axis_tready never reaches it combinationally.
  assign s_axis_tready = (state_q == LOCKED && !full_q) ? grant_q : '0;
  assign push          = |(s_axis_tvalid & s_axis_tready);
  assign pop           = m_axis_tvalid && m_axis_tready;
  assign grant_idx     = onehot_to_idx(16'(grant_q));

  always_comb begin
    in_beat = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      if (grant_q[i]) begin
        in_beat.data = s_axis_tdata[i*DATA_W +: DATA_W];
        in_beat.keep = s_axis_tkeep[i*KEEP_W +: KEEP_W];
        in_beat.last = s_axis_tlast[i];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          grant_d = winner;
          state_d = LOCKED;
        end
      end
      LOCKED: begin
        if (push && in_beat.last) begin
          grant_d  = '0;
          state_d  = IDLE;
          rr_ptr_d = PTR_W'((grant_idx + 1) % N_PORTS);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Head always holds the oldest beat; tail is only used when two beats are held.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    case (count_q)
      2'd0: begin
        if (push) begin
          head_d  = in_beat;
          count_d = 2'd1;
        end
      end
      2'd1: begin
        if (push && pop) begin
          head_d = in_beat;
        end else if (push) begin
          tail_d  = in_beat;
          count_d = 2'd2;
        end else if (pop) begin
          count_d = 2'd0;
        end
      end
      default: begin
        if (pop) begin
          head_d  = tail_q;
          count_d = 2'd1;
        end
      end
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      full_q   <= (count_d == 2'd2);
    end
  end

  assign m_axis_tvalid = (count_q != 2'd0);
  assign m_axis_tdata  = head_q.data;
  assign m_axis_tkeep  = head_q.keep;
  assign m_axis_tlast  = head_q.last;
  assign grant         = grant_q;
  assign busy          = (state_q == LOCKED);

endmodule

// File: tb/tb_axis_pkt_arbiter.sv
// Self-checking bench: queue-based packet model checked every cycle, plus directed scenarios.
module tb_axis_pkt_arbiter;

  localparam int N  = 4;
  localparam int DW = 512;
  localparam int KW = 64;

  logic            aclk = 1'b0;
  logic            areset;
  logic [N-1:0]    s_axis_tvalid;
  logic [N-1:0]    s_axis_tready;
  logic [N*DW-1:0] s_axis_tdata;
  logic [N*KW-1:0] s_axis_tkeep;
  logic [N-1:0]    s_axis_tlast;
  logic            m_axis_tvalid;
  logic            m_axis_tready;
  logic [DW-1:0]   m_axis_tdata;
  logic [KW-1:0]   m_axis_tkeep;
  logic            m_axis_tlast;
  logic [N-1:0]    grant;
  logic            busy;

  axis_pkt_arbiter #(.N_PORTS(N), .DATA_W(DW)) dut (
    .aclk         (aclk),
    .areset       (areset),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tkeep (s_axis_tkeep),
    .s_axis_tlast (s_axis_tlast),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tkeep (m_axis_tkeep),
    .m_axis_tlast (m_axis_tlast),
    .grant        (grant),
    .busy         (busy)
  );

  always #5 aclk = ~aclk;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
  } tbeat_t;

  tbeat_t        pq[N][$];
  tbeat_t        expq[$];
  logic [N-1:0]  vld;
  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  bit            locked;
  int            owner;
  int            last_served;
  int            ready_pct;
  int            gap_pct;
  logic [DW-1:0] out_data[$];
  int            out_cyc[$];
  logic          out_last[$];
  int            arb_port[$];
  int            arb_cyc[$];
  int            tlast_cyc[$];
  int            sfire_cnt[N];
  int            g0_cnt;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] rand_word();
    logic [DW-1:0] w;
    for (int i = 0; i < DW/32; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  task automatic add_pkt(input int p, input int len, input logic [DW-1:0] first, input bit rnd);
    tbeat_t b;
    for (int k = 0; k < len; k++) begin
      b.data = rnd ? rand_word() : first + DW'(k);
      b.keep = rnd ? {$urandom, $urandom} : '1;
      b.last = (k == len - 1);
      pq[p].push_back(b);
    end
  endtask

  task automatic clear_logs();
    out_data.delete(); out_cyc.delete(); out_last.delete();
    arb_port.delete(); arb_cyc.delete(); tlast_cyc.delete();
    for (int i = 0; i < N; i++) sfire_cnt[i] = 0;
    g0_cnt = 0;
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (!vld[i] && pq[i].size() > 0 && ($urandom_range(99) >= gap_pct)) vld[i] = 1'b1;
      s_axis_tvalid[i] = vld[i];
      if (pq[i].size() > 0) begin
        s_axis_tdata[i*DW +: DW] = pq[i][0].data;
        s_axis_tkeep[i*KW +: KW] = pq[i][0].keep;
        s_axis_tlast[i]          = pq[i][0].last;
      end else begin
        s_axis_tdata[i*DW +: DW] = '0;
        s_axis_tkeep[i*KW +: KW] = '0;
        s_axis_tlast[i]          = 1'b0;
      end
    end
  endtask

  // One clock cycle: check outputs against the model, drive, then advance the model.
  task automatic step();
    logic [N-1:0] exp_g, exp_r, tr, sf;
    logic         mv, mf;
    int           p;
    @(negedge aclk);
    cyc++;
    exp_g = locked ? (N'(1) << owner) : '0;
    exp_r = (locked && expq.size() < 2) ? exp_g : '0;
    chk("grant", grant, exp_g);
    chk("grant_onehot0", $onehot0(grant), 1);
    chk("busy", busy, locked);
    chk("s_tready", s_axis_tready, exp_r);
    chk("m_tvalid", m_axis_tvalid, expq.size() > 0);
    if (expq.size() > 0 && m_axis_tvalid) begin
      chk("m_tdata", m_axis_tdata, expq[0].data);
      chk("m_tkeep", m_axis_tkeep, expq[0].keep);
      chk("m_tlast", m_axis_tlast, expq[0].last);
    end
    if (grant == 4'b0001) g0_cnt++;
    tr = s_axis_tready;
    mv = m_axis_tvalid;
    m_axis_tready = ($urandom_range(99) < ready_pct);
    drive();
    sf = s_axis_tvalid & tr;
    mf = mv && m_axis_tready;
    if (mf && expq.size() > 0) begin
      $display("beat cyc=%0d data=%08h keep=%016h last=%0b", cyc, m_axis_tdata[31:0], m_axis_tkeep, m_axis_tlast);
      out_data.push_back(m_axis_tdata);
      out_cyc.push_back(cyc);
      out_last.push_back(m_axis_tlast);
      void'(expq.pop_front());
    end
    if (!locked && |s_axis_tvalid) begin
      for (int k = 0; k < N; k++) begin
        p = (last_served + 1 + k) % N;
        if (s_axis_tvalid[p]) begin
          owner = p;
          break;
        end
      end
      locked = 1'b1;
      arb_port.push_back(owner);
      arb_cyc.push_back(cyc);
    end
    for (int i = 0; i < N; i++) begin
      if (sf[i] && pq[i].size() > 0) begin
        expq.push_back(pq[i][0]);
        sfire_cnt[i]++;
        if (locked && i == owner && pq[i][0].last) begin
          locked      = 1'b0;
          last_served = owner;
          tlast_cyc.push_back(cyc);
        end
        void'(pq[i].pop_front());
        vld[i] = 1'b0;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge aclk);
    cyc++;
    areset        = 1'b1;
    m_axis_tready = 1'b0;
    s_axis_tvalid = '0;
    s_axis_tdata  = '0;
    s_axis_tkeep  = '0;
    s_axis_tlast  = '0;
    vld           = '0;
    for (int i = 0; i < N; i++) pq[i].delete();
    expq.delete();
    locked      = 1'b0;
    owner       = 0;
    last_served = N - 1;
    @(negedge aclk);
    cyc++;
    areset = 1'b0;
    chk("rst_m_tvalid", m_axis_tvalid, 0);
    chk("rst_m_tdata", m_axis_tdata, '0);
    chk("rst_m_tkeep", m_axis_tkeep, '0);
    chk("rst_m_tlast", m_axis_tlast, 0);
    chk("rst_s_tready", s_axis_tready, 0);
    chk("rst_grant", grant, 0);
    chk("rst_busy", busy, 0);
  endtask

  function automatic bit model_busy();
    bit b;
    b = locked || (expq.size() > 0);
    for (int i = 0; i < N; i++) if (pq[i].size() > 0) b = 1'b1;
    return b;
  endfunction

  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while (model_busy() && n < budget) begin
      step();
      n++;
    end
    chk({name, "_drain_in_budget"}, (n < budget), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog cyc=%0d got=running expected=finished", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    areset = 1'b1;
    m_axis_tready = 1'b0;
    s_axis_tvalid = '0;
    s_axis_tdata = '0;
    s_axis_tkeep = '0;
    s_axis_tlast = '0;
    vld = '0;
    ready_pct = 100;
    gap_pct = 0;
    repeat (3) @(negedge aclk);
    do_reset();

    // Single 3-beat packet from port 0.
    clear_logs();
    add_pkt(0, 3, DW'(1), 1'b0);
    drain("t1", 50);
    chk("t1_arb_n", arb_port.size(), 1);
    chk("t1_winner", arb_port[0], 0);
    chk("t1_out_n", out_cyc.size(), 3);
    if (out_cyc.size() == 3) begin
      for (int k = 0; k < 3; k++) begin
        chk("t1_out_cyc", out_cyc[k], arb_cyc[0] + 2 + k);
        chk("t1_out_data", out_data[k], DW'(k + 1));
        chk("t1_out_last", out_last[k], (k == 2));
      end
    end
    chk("t1_grant_cycles", g0_cnt, 3);

    // All ports continuously valid with 2-beat packets.
    do_reset();
    clear_logs();
    for (int r = 0; r < 2; r++)
      for (int p = 0; p < N; p++) add_pkt(p, 2, '0, 1'b1);
    drain("t2", 100);
    chk("t2_arb_n", arb_port.size(), 8);
    if (arb_port.size() == 8) begin
      for (int k = 0; k < 8; k++) chk("t2_order", arb_port[k], k % N);
      for (int k = 1; k < 8; k++) chk("t2_spacing", arb_cyc[k] - arb_cyc[k-1], 3);
    end
    chk("t2_out_n", out_last.size(), 16);
    if (out_last.size() == 16)
      for (int k = 0; k < 16; k++) chk("t2_last_pattern", out_last[k], k % 2);

    // Port 1 requests while port 2 is mid-packet.
    clear_logs();
    add_pkt(2, 4, '0, 1'b1);
    n = 0;
    while (sfire_cnt[2] < 2 && n < 30) begin step(); n++; end
    chk("t3_reach_beat2", (n < 30), 1);
    add_pkt(1, 3, '0, 1'b1);
    drain("t3", 60);
    chk("t3_arb_n", arb_port.size(), 2);
    if (arb_port.size() == 2 && tlast_cyc.size() >= 1) begin
      chk("t3_first", arb_port[0], 2);
      chk("t3_second", arb_port[1], 1);
      chk("t3_regrant_gap", arb_cyc[1], tlast_cyc[0] + 1);
    end

    // Downstream stall of 5 cycles during an 8-beat packet.
    clear_logs();
    add_pkt(0, 8, DW'('h41), 1'b0);
    n = 0;
    while (sfire_cnt[0] < 3 && n < 30) begin step(); n++; end
    chk("t4_reach_beat3", (n < 30), 1);
    ready_pct = 0;
    repeat (5) step();
    chk("t4_stall_tready", s_axis_tready, 0);
    chk("t4_stall_mvalid", m_axis_tvalid, 1);
    chk("t4_accepted_at_stall", sfire_cnt[0], 4);
    ready_pct = 100;
    drain("t4", 60);
    chk("t4_out_n", out_data.size(), 8);
    if (out_data.size() == 8)
      for (int k = 0; k < 8; k++) chk("t4_out_data", out_data[k], DW'('h41 + k));

    // Reset in the middle of a 6-beat packet from port 3.
    clear_logs();
    add_pkt(3, 6, '0, 1'b1);
    n = 0;
    while (sfire_cnt[3] < 3 && n < 30) begin step(); n++; end
    chk("t5_reach_beat3", (n < 30), 1);
    do_reset();
    clear_logs();
    add_pkt(0, 2, '0, 1'b1);
    add_pkt(3, 2, '0, 1'b1);
    drain("t5", 60);
    chk("t5_arb_n", arb_port.size(), 2);
    if (arb_port.size() == 2) begin
      chk("t5_first", arb_port[0], 0);
      chk("t5_second", arb_port[1], 3);
    end

    // Back-to-back single-beat packets from port 1 only.
    clear_logs();
    for (int k = 0; k < 6; k++) add_pkt(1, 1, '0, 1'b1);
    drain("t6", 60);
    chk("t6_arb_n", arb_port.size(), 6);
    if (arb_port.size() == 6) begin
      for (int k = 0; k < 6; k++) chk("t6_winner", arb_port[k], 1);
      for (int k = 1; k < 6; k++) chk("t6_spacing", arb_cyc[k] - arb_cyc[k-1], 2);
    end

    // Randomized traffic with source gaps and downstream back-pressure.
    clear_logs();
    ready_pct = 70;
    gap_pct = 30;
    for (int k = 0; k < 40; k++) add_pkt($urandom_range(N-1), $urandom_range(6, 1), '0, 1'b1);
    drain("t7", 5000);
    ready_pct = 100;
    gap_pct = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
